program_counter_seq: RTL

Next-generation program counter for the processor fetch path. It replaces the increment-only PC with a width-parametrised counter supporting:
- sequential increment,
- absolute jump,
- PC-relative branch,
- call/return through an internal return-address stack.

It drives the instruction-memory address bus and is advanced by the control unit's WrPC strobe.

---
 rtl/program_counter_seq_pkg.sv | 29 ++
 rtl/pc_return_stack.sv | 55 +++++
 rtl/program_counter_seq.sv | 115 +++++++++++
 3 files changed

// File: rtl/program_counter_seq_pkg.sv
// Shared encodings and defaults for the fetch-path program counter and its control unit.
`default_nettype none

package program_counter_seq_pkg;

  localparam int DEFAULT_BITS_ADDRESS = 11;
  localparam int DEFAULT_RESET_VECTOR = 0;

  typedef enum logic [2:0] {
    PC_INC    = 3'd0,
    PC_JUMP   = 3'd1,
    PC_BRANCH = 3'd2,
    PC_CALL   = 3'd3,
    PC_RET    = 3'd4
  } pc_action_e;

  // Priority ret > call > jump > branch > increment.
  function automatic pc_action_e pc_select(input logic jump, input logic branch,
                                           input logic call, input logic ret);
    if (ret)         return PC_RET;
    else if (call)   return PC_CALL;
    else if (jump)   return PC_JUMP;
    else if (branch) return PC_BRANCH;
    else             return PC_INC;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_return_stack.sv
// Return-address LIFO: push writes din on top, pop discards top; dout shows the current top.
`default_nettype none

module pc_return_stack #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_FULL = PW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    ptr_d;
  logic [PW-1:0]    top_ptr;
  logic             wr_en;

  assign empty   = (ptr_q == '0);
  assign full    = (ptr_q == PTR_FULL);
  assign top_ptr = ptr_q - PTR_ONE;
  assign dout    = mem_q[top_ptr[IW-1:0]];
  assign wr_en   = push && !full && !reset;

  always_comb begin
    ptr_d = ptr_q;
    if (push && !full)
      ptr_d = ptr_q + PTR_ONE;
    else if (pop && !empty)
      ptr_d = ptr_q - PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  // Contents need no reset: the pointer alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[ptr_q[IW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/program_counter_seq.sv
// Fetch-path PC with increment/jump/branch and call/ret via a return stack.
// Return stack and call/ret semantics are present only when PC_RETURN_STACK_EN is defined.
`default_nettype none

module program_counter_seq
  import program_counter_seq_pkg::*;
#(
  parameter int          bits_address = DEFAULT_BITS_ADDRESS,
  parameter int unsigned RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int          STACK_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    WrPC,
  input  logic                    jump,
  input  logic                    branch,
  input  logic                    call,
  input  logic                    ret,
  input  logic [bits_address-1:0] target_addr,
  input  logic [bits_address-1:0] offset,
  output logic [bits_address-1:0] address_bus,
  output logic                    stack_empty,
  output logic                    stack_full,
  output logic                    stack_err
);

  localparam logic [bits_address-1:0] PC_ONE   = bits_address'(1);
  localparam logic [bits_address-1:0] PC_RESET = bits_address'(RESET_VECTOR);

  if (STACK_DEPTH < 1) begin : g_depth_check
    $error("program_counter_seq: STACK_DEPTH must be at least 1");
  end

  logic [bits_address-1:0] pc_q, pc_d, pc_plus1;
  logic                    err_q, err_d;
  logic [bits_address-1:0] stk_top;
  logic                    stk_empty, stk_full;
  pc_action_e              action;

`ifdef PC_RETURN_STACK_EN
  localparam bit STACK_EN = 1'b1;

  logic stk_push, stk_pop;

  always_comb begin
    stk_push = WrPC && (action == PC_CALL) && !stk_full;
    stk_pop  = WrPC && (action == PC_RET) && !stk_empty;
  end

  pc_return_stack #(
    .WIDTH (bits_address),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (pc_plus1),
    .dout  (stk_top),
    .empty (stk_empty),
    .full  (stk_full)
  );
`else
  localparam bit STACK_EN = 1'b0;

  // Without a stack, ret always sees "empty" and so falls through to increment.
  assign stk_top   = '0;
  assign stk_empty = 1'b1;
  assign stk_full  = 1'b0;
`endif

  always_comb begin
    action   = pc_select(jump, branch, call, ret);
    pc_plus1 = pc_q + PC_ONE;
    pc_d     = pc_q;
    err_d    = err_q;
    if (WrPC) begin
      case (action)
        PC_RET: begin
          if (!stk_empty) begin
            pc_d = stk_top;
          end else begin
            pc_d = pc_plus1;
            if (STACK_EN) err_d = 1'b1;
          end
        end
        PC_CALL: begin
          pc_d = target_addr;
          if (STACK_EN && stk_full) err_d = 1'b1;
        end
        PC_JUMP:   pc_d = target_addr;
        PC_BRANCH: pc_d = pc_q + offset;
        default:   pc_d = pc_plus1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= PC_RESET;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign address_bus = pc_q;
  assign stack_empty = stk_empty;
  assign stack_full  = stk_full;
  assign stack_err   = err_q;

endmodule

`default_nettype wire
